// File: rtl/leitor_controle_genesis_pkg.sv
// Shared definitions for the Genesis joypad reader: FSM states, Saidas bit
// indices and the Select phase count.
package leitor_controle_genesis_pkg;

  localparam int N_PHASES = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_X     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_Z     = 10;
  localparam int BTN_MODE  = 11;

  // P0..P7 are consecutive so the FSM can step through them by increment.
  typedef enum logic [3:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3, S_P4, S_P5, S_P6, S_P7, S_COMMIT
  } state_t;

  function automatic logic select_level(input state_t s);
    return !(s == S_P0 || s == S_P2 || s == S_P4 || s == S_P6);
  endfunction

endpackage

// File: rtl/leitor_controle_genesis_sincronizador.sv
// Multi-stage synchroniser with falling-edge detect on the synchronised output.
// Resets to all ones, matching the idle level of the pad pins and v_sync.
module leitor_controle_genesis_sincronizador #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] stage [STAGES];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '1;
      prev <= '1;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[STAGES-1];
    end
  end

  assign q    = stage[STAGES-1];
  assign fall = prev & ~q;

endmodule

// File: rtl/leitor_controle_genesis.sv
// Mega Drive/Genesis 3/6-button joypad reader, one read per v_sync frame,
// with frame-word debounce on the published button word.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | Select high, waiting for a synchronised v_sync falling edge
// S_P0     | Select low: presence detect, A, Start
// S_P1     | Select high: Up/Down/Left/Right, B, C
// S_P2/P3  | counter cycling only
// S_P4     | Select low: 6-button detect
// S_P5     | Select high: Z/Y/X/Mode when 6-button
// S_P6/P7  | counter cycling only
// S_COMMIT | update Presente/Seis, debounce and publish Saidas
module leitor_controle_genesis
  import leitor_controle_genesis_pkg::*;
#(
  parameter int PHASE_CYCLES    = 500,
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        Clock50,
  input  logic        Reset,
  input  logic        Pino1,
  input  logic        Pino2,
  input  logic        Pino3,
  input  logic        Pino4,
  input  logic        Pino6,
  input  logic        Pino9,
  input  logic        v_sync,
  output logic        Select,
  output logic [11:0] Saidas,
  output logic        Novo,
  output logic        Presente,
  output logic        Seis
);

  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(PHASE_CYCLES - 1);
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_FRAMES);

  logic [5:0] pin_sync;
  logic [5:0] pin_fall;
  logic       vs_sync;
  logic       vs_fall;

  leitor_controle_genesis_sincronizador #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_sync_pinos (
    .clk   (Clock50),
    .reset (Reset),
    .d     ({Pino9, Pino6, Pino4, Pino3, Pino2, Pino1}),
    .q     (pin_sync),
    .fall  (pin_fall)
  );

  leitor_controle_genesis_sincronizador #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk   (Clock50),
    .reset (Reset),
    .d     (v_sync),
    .q     (vs_sync),
    .fall  (vs_fall)
  );

  // Pins are active-low; work with pressed = 1 from here on.
  logic p1, p2, p3, p4, p6, p9;
  assign {p9, p6, p4, p3, p2, p1} = ~pin_sync;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [11:0]   raw_w;
  logic          pres_det;
  logic          six_det;
  logic [11:0]   prev_raw;
  logic [DW-1:0] dbcnt;
  logic [11:0]   raw_eff;
  logic [DW-1:0] db_next;

  always_comb begin
    raw_eff = pres_det ? raw_w : 12'h000;
    db_next = DW'(1);
    if (raw_eff == prev_raw)
      db_next = (dbcnt < DB_MAX) ? dbcnt + DW'(1) : dbcnt;
  end

  always_ff @(posedge Clock50) begin
    if (Reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      Select   <= 1'b1;
      Saidas   <= 12'h000;
      Novo     <= 1'b0;
      Presente <= 1'b0;
      Seis     <= 1'b0;
      raw_w    <= 12'h000;
      pres_det <= 1'b0;
      six_det  <= 1'b0;
      prev_raw <= 12'h000;
      dbcnt    <= '0;
    end else begin
      Novo <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vs_fall) begin
            state    <= S_P0;
            cnt      <= CNT_LOAD;
            Select   <= 1'b0;
            raw_w    <= 12'h000;
            pres_det <= 1'b0;
            six_det  <= 1'b0;
          end
        end
        S_COMMIT: begin
          Presente <= pres_det;
          Seis     <= six_det;
          prev_raw <= raw_eff;
          dbcnt    <= db_next;
          if (db_next >= DB_MAX) begin
            Saidas <= raw_eff;
            Novo   <= 1'b1;
          end
          state  <= S_IDLE;
          Select <= 1'b1;
        end
        default: begin
          if (cnt == '0) begin
            case (state)
              S_P0: begin
                pres_det         <= p3 & p4;
                raw_w[BTN_A]     <= p6;
                raw_w[BTN_START] <= p9;
              end
              S_P1: begin
                raw_w[BTN_UP]    <= p1;
                raw_w[BTN_DOWN]  <= p2;
                raw_w[BTN_LEFT]  <= p3;
                raw_w[BTN_RIGHT] <= p4;
                raw_w[BTN_B]     <= p6;
                raw_w[BTN_C]     <= p9;
              end
              S_P4: six_det <= p1 & p2 & p3 & p4;
              S_P5: begin
                if (six_det) begin
                  raw_w[BTN_Z]    <= p1;
                  raw_w[BTN_Y]    <= p2;
                  raw_w[BTN_X]    <= p3;
                  raw_w[BTN_MODE] <= p4;
                end else begin
                  raw_w[11:8] <= 4'h0;
                end
              end
              default: ;
            endcase
            state  <= state_t'(state + 4'd1);
            cnt    <= CNT_LOAD;
            Select <= select_level(state_t'(state + 4'd1));
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_controle_genesis.sv
// Bench for leitor_controle_genesis: behavioural joypad, frame-level reference
// model and a Novo-driven scoreboard.
module tb_leitor_controle_genesis;

  localparam int PC  = 4;
  localparam int DB  = 2;
  localparam int SS  = 2;
  localparam int LAT = SS + 1 + 8 * PC + 1;

  logic        Clock50 = 1'b0;
  logic        Reset   = 1'b1;
  logic        Pino1, Pino2, Pino3, Pino4, Pino6, Pino9;
  logic        v_sync  = 1'b1;
  logic        Select;
  logic [11:0] Saidas;
  logic        Novo, Presente, Seis;

  leitor_controle_genesis #(.PHASE_CYCLES(PC), .DEBOUNCE_FRAMES(DB), .SYNC_STAGES(SS)) dut (
    .Clock50 (Clock50), .Reset (Reset),
    .Pino1 (Pino1), .Pino2 (Pino2), .Pino3 (Pino3), .Pino4 (Pino4),
    .Pino6 (Pino6), .Pino9 (Pino9), .v_sync (v_sync),
    .Select (Select), .Saidas (Saidas), .Novo (Novo),
    .Presente (Presente), .Seis (Seis)
  );

  always #10 Clock50 = ~Clock50;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge Clock50) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Joypad: counts Select falling edges, resets its count after a 30-cycle idle.
  int          pad_mode = 0;        // 0 absent, 3 three-button, 6 six-button
  logic [11:0] btn = 12'h000;       // pressed = 1, Saidas bit order
  int          nf = 0;
  int          last_fall = -1000;

  always @(negedge Select) begin
    if (cyc - last_fall > 30) nf <= 1;
    else if (nf < 4) nf <= nf + 1;
    last_fall <= cyc;
  end

  always_comb begin
    {Pino1, Pino2, Pino3, Pino4, Pino6, Pino9} = 6'b111111;
    if (pad_mode != 0) begin
      if (!Select) begin
        if (pad_mode == 6 && nf == 3)      {Pino1, Pino2, Pino3, Pino4} = 4'b0000;
        else if (pad_mode == 6 && nf == 4) {Pino1, Pino2, Pino3, Pino4} = 4'b1111;
        else {Pino1, Pino2, Pino3, Pino4} = {~btn[0], ~btn[1], 2'b00};
        Pino6 = ~btn[4];
        Pino9 = ~btn[7];
      end else begin
        if (pad_mode == 6 && nf == 3) {Pino1, Pino2, Pino3, Pino4} = {~btn[10], ~btn[9], ~btn[8], ~btn[11]};
        else {Pino1, Pino2, Pino3, Pino4} = {~btn[0], ~btn[1], ~btn[2], ~btn[3]};
        Pino6 = ~btn[5];
        Pino9 = ~btn[6];
      end
    end
  end

  int   toggles = 0;
  logic sel_prev = 1'b1;
  always @(negedge Clock50) begin
    if (Select !== sel_prev) toggles <= toggles + 1;
    sel_prev <= Select;
  end

  typedef struct packed { logic [11:0] s; logic p; logic x; } exp_t;
  exp_t sb[$];
  int   last_novo_cyc = -1;

  always @(negedge Clock50) begin
    if (Novo === 1'b1) begin
      last_novo_cyc <= cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL novo_unexpected: got Novo=1 with Saidas=0x%0h, required no commit", Saidas);
      end else begin
        check("sb_saidas", int'(Saidas), int'(sb[0].s));
        check("sb_presente", int'(Presente), int'(sb[0].p));
        check("sb_seis", int'(Seis), int'(sb[0].x));
        void'(sb.pop_front());
      end
    end
  end

  // Frame-level reference: what the pad reports and how debounce reacts.
  logic [11:0] m_prev = 12'h000;
  logic [11:0] m_saidas = 12'h000;
  int          m_db = 0;

  function automatic logic [11:0] pad_word(input int mode, input logic [11:0] b);
    if (mode == 0) return 12'h000;
    if (mode == 3) return b & 12'h0FF;
    return b;
  endfunction

  task automatic model_frame();
    logic [11:0] raw;
    raw = pad_word(pad_mode, btn);
    if (raw == m_prev) m_db = (m_db < DB) ? m_db + 1 : m_db;
    else m_db = 1;
    m_prev = raw;
    if (m_db >= DB) begin
      m_saidas = raw;
      sb.push_back({raw, pad_mode != 0, pad_mode == 6});
    end
  endtask

  task automatic run_frame(input bit glitch, input bit lat_chk, input int rst_at);
    int t0, tg0;
    if (rst_at == 0) model_frame();
    @(posedge Clock50); #1;
    tg0 = toggles;
    v_sync = 1'b0;
    t0 = cyc;
    for (int i = 1; i <= 50; i++) begin
      @(posedge Clock50); #1;
      if (i == 4) v_sync = 1'b1;
      if (glitch && i == 13) v_sync = 1'b0;
      if (glitch && i == 16) v_sync = 1'b1;
      if (rst_at != 0 && i == rst_at) Reset = 1'b1;
      if (rst_at != 0 && i == rst_at + 1) begin
        check("rst_mid_select", int'(Select), 1);
        check("rst_mid_saidas", int'(Saidas), 0);
        check("rst_mid_presente", int'(Presente), 0);
        check("rst_mid_seis", int'(Seis), 0);
        check("rst_mid_novo", int'(Novo), 0);
      end
      if (rst_at != 0 && i == rst_at + 3) begin
        Reset = 1'b0;
        tg0 = toggles;
        m_prev = 12'h000; m_saidas = 12'h000; m_db = 0;
        sb.delete();
      end
    end
    if (rst_at == 0) begin
      check("presente", int'(Presente), int'(pad_mode != 0));
      check("seis", int'(Seis), int'(pad_mode == 6));
      check("saidas", int'(Saidas), int'(m_saidas));
      check("select_toggles", toggles - tg0, 8);
      if (lat_chk) check("latency", last_novo_cyc - t0, LAT);
    end else begin
      check("idle_after_reset_toggles", toggles - tg0, 0);
      check("saidas_after_reset", int'(Saidas), 0);
    end
    repeat (20) @(posedge Clock50);
  endtask

  initial begin
    int hold;
    // 1. reset
    repeat (5) @(posedge Clock50);
    #1;
    check("rst_hold_select", int'(Select), 1);
    Reset = 1'b0;
    @(posedge Clock50); #1;
    check("rst_select", int'(Select), 1);
    check("rst_saidas", int'(Saidas), 0);
    check("rst_presente", int'(Presente), 0);
    check("rst_seis", int'(Seis), 0);
    check("rst_novo", int'(Novo), 0);
    begin
      int tg = toggles;
      repeat (40) @(posedge Clock50);
      #1;
      check("no_read_without_vsync", toggles - tg, 0);
    end

    // 2. 3-button, A+Up
    pad_mode = 3; btn = 12'h011;
    run_frame(0, 0, 0);
    check("t2_frame1_saidas", int'(Saidas), 0);
    run_frame(0, 1, 0);
    check("t2_saidas", int'(Saidas), 12'h011);

    // 3. 6-button, X+Mode
    pad_mode = 6; btn = 12'h900;
    run_frame(0, 0, 0);
    run_frame(0, 0, 0);
    check("t3_saidas", int'(Saidas), 12'h900);
    check("t3_seis", int'(Seis), 1);

    // 4. absent
    pad_mode = 0; btn = 12'h0FF;
    repeat (3) run_frame(0, 0, 0);
    check("t4_presente", int'(Presente), 0);
    check("t4_saidas", int'(Saidas), 0);

    // 5. single-frame B blip
    pad_mode = 3; btn = 12'h000;
    run_frame(0, 0, 0); run_frame(0, 0, 0);
    btn = 12'h020;
    run_frame(0, 0, 0);
    check("t5_blip_saidas", int'(Saidas), 0);
    btn = 12'h000;
    run_frame(0, 0, 0); run_frame(0, 0, 0);
    check("t5_after_saidas", int'(Saidas), 0);

    // 6. v_sync glitch in P3, then reset in P5
    pad_mode = 6; btn = 12'h900;
    run_frame(0, 0, 0);
    run_frame(1, 1, 0);
    check("t6_glitch_saidas", int'(Saidas), 12'h900);
    run_frame(0, 0, 24);
    run_frame(0, 0, 0);

    // 7. randomized frames
    for (int k = 0; k < 8; k++) begin
      pad_mode = ($urandom_range(0, 1) == 0) ? 3 : 6;
      btn = 12'($urandom_range(0, 4095));
      if (pad_mode == 3 && btn[0] && btn[1]) btn[1] = 1'b0;
      hold = $urandom_range(1, 3);
      for (int f = 0; f < hold; f++) run_frame(0, 0, 0);
    end

    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
